// File: rtl/ifetch_q.sv
// ifetch_q
// Instruction fetch stage with a small prefetch queue, sitting directly in
// front of the decoder. It owns the fetch PC, issues reads to instruction
// memory (fixed 1-cycle read latency), buffers returned words together with
// their PCs, and presents the head entry to the decoder with a valid/ready
// handshake. A PC write from exec (redirect) flushes the queue; a HALT
// accepted at the head stops fetching and drains the last outstanding read.
//
// Parameters
//   IW     instruction width
//   AW     instruction address / PC width
//   DEPTH  prefetch queue entries (power of two, >= 2)
//
// Ports
//   clk          in   clock, all state on rising edge
//   rst          in   synchronous reset, active-high
//   imem_req     out  read request
//   imem_addr    out  read address (fetch PC)
//   imem_gnt     in   memory accepts the request this cycle
//   imem_rvalid  in   read data valid, one cycle after an accepted request
//   imem_rdata   in   read data
//   ins          out  head instruction (NOP when queue empty)
//   ins_pc       out  PC of head instruction (0 when queue empty)
//   ins_valid    out  head entry valid
//   ins_ready    in   decoder consumes the head this cycle
//   redirect     in   PC write from exec
//   redirect_pc  in   new PC for redirect
//   halt         in   decoder HALT, sampled only on a head pop
//   halted       out  fetch stopped and pipeline drained

module ifetch_q #(
  parameter int IW    = 16,
  parameter int AW    = 8,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic          imem_gnt,
  input  logic          imem_rvalid,
  input  logic [IW-1:0] imem_rdata,
  output logic [IW-1:0] ins,
  output logic [AW-1:0] ins_pc,
  output logic          ins_valid,
  input  logic          ins_ready,
  input  logic          redirect,
  input  logic [AW-1:0] redirect_pc,
  input  logic          halt,
  output logic          halted
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nxt;

  logic [AW-1:0] fpc;
  logic [AW-1:0] issue_pc;
  logic [CW-1:0] count;
  logic [PW-1:0] rdptr;
  logic [PW-1:0] wrptr;
  logic          pend;
  logic          drop;

  logic [IW-1:0] q_ins [DEPTH];
  logic [AW-1:0] q_pc  [DEPTH];

  logic          run;
  logic          pop;
  logic          halt_take;
  logic          redir;
  logic          flush;
  logic          credit;
  logic          accept;
  logic          push;
  logic [CW:0]   inflight;

  // Handshake decode. A halt accepted at the head takes priority over a
  // concurrent redirect, and any flush overrides the pop and the return.
  // Credit counts the outstanding read so a returning word always has a slot.
  always_comb begin
    run       = (state == RUN);
    pop       = run && (count != '0) && ins_ready;
    halt_take = pop && halt;
    redir     = run && redirect && !halt_take;
    flush     = redir || halt_take;
    inflight  = {1'b0, count} + {{CW{1'b0}}, pend};
    credit    = (inflight < (CW+1)'(DEPTH));
    imem_req  = run && !rst && credit && !redirect && !halt_take;
    imem_addr = fpc;
    accept    = imem_req && imem_gnt;
    push      = imem_rvalid && !drop && run && !flush;
  end

  // Next-state logic: RUN -> DRAIN on an accepted halt, DRAIN -> HALTED once
  // the last read has come back, HALTED is left only through reset.
  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (halt_take) state_nxt = DRAIN;
      DRAIN:   if (!pend)     state_nxt = HALTED;
      HALTED:  state_nxt = HALTED;
      default: state_nxt = RUN;
    endcase
  end

  // Head presentation; an empty queue (or a stopped fetch) shows a NOP at PC 0.
  always_comb begin
    ins_valid = run && (count != '0);
    ins       = '0;
    ins_pc    = '0;
    if (ins_valid) begin
      ins    = q_ins[rdptr];
      ins_pc = q_pc[rdptr];
    end
    halted = (state == HALTED);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= RUN;
    else     state <= state_nxt;
  end

  // Fetch PC and outstanding-read tracking. issue_pc remembers which PC the
  // in-flight read belongs to so the returning word can be tagged with it.
  // drop covers a read still in flight past a flush; with a strict 1-cycle
  // memory the return always coincides with the flush and is gated there.
  always_ff @(posedge clk) begin
    if (rst) begin
      fpc      <= '0;
      issue_pc <= '0;
      pend     <= 1'b0;
      drop     <= 1'b0;
    end else begin
      if (redir)       fpc <= redirect_pc;
      else if (accept) fpc <= fpc + AW'(1);

      if (accept) issue_pc <= fpc;

      if (accept)           pend <= 1'b1;
      else if (imem_rvalid) pend <= 1'b0;

      if (flush && pend && !imem_rvalid) drop <= 1'b1;
      else if (imem_rvalid)              drop <= 1'b0;
    end
  end

  // Queue occupancy and pointers; a flush clears everything on the same edge.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      count <= '0;
      rdptr <= '0;
      wrptr <= '0;
    end else begin
      if (push) wrptr <= wrptr + PW'(1);
      if (pop)  rdptr <= rdptr + PW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

  // Queue storage; contents are only meaningful below count, so no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      q_ins[wrptr] <= imem_rdata;
      q_pc[wrptr]  <= issue_pc;
    end
  end

  // The credit scheme must never let a word land in a full queue.
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    push |-> ((count < CW'(DEPTH)) || pop));

endmodule

// File: tb/tb_ifetch_q.sv
// Directed bench for ifetch_q. A behavioural instruction memory answers every
// accepted request one cycle later with data = address + 16'h0400. Inputs are
// changed one time unit after each rising edge and outputs are checked one
// time unit after that, well away from the next edge.

module tb_ifetch_q;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [15:0] imem_rdata;
  logic [15:0] ins;
  logic [7:0]  ins_pc;
  logic        ins_valid;
  logic        ins_ready;
  logic        redirect;
  logic [7:0]  redirect_pc;
  logic        halt;
  logic        halted;

  int compared;
  int mismatched;

  ifetch_q #(.IW(16), .AW(8), .DEPTH(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .ins         (ins),
    .ins_pc      (ins_pc),
    .ins_valid   (ins_valid),
    .ins_ready   (ins_ready),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .halt        (halt),
    .halted      (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory: fixed 1-cycle latency, mem[a] = a + 16'h0400.
  always @(posedge clk) begin
    if (rst) begin
      imem_rvalid <= 1'b0;
      imem_rdata  <= 16'h0000;
    end else begin
      imem_rvalid <= imem_req & imem_gnt;
      imem_rdata  <= {8'h00, imem_addr} + 16'h0400;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic rdy, input logic gnt, input logic rdr,
                               input logic [7:0] rpc, input logic hlt);
    ins_ready   = rdy;
    imem_gnt    = gnt;
    redirect    = rdr;
    redirect_pc = rpc;
    halt        = hlt;
    #1;
  endtask

  task automatic resetDut();
    rst = 1'b1;
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
    tick();
    tick();
    checkOutput("rst_req",    {31'd0, imem_req},  32'd0);
    checkOutput("rst_addr",   {24'd0, imem_addr}, 32'd0);
    checkOutput("rst_valid",  {31'd0, ins_valid}, 32'd0);
    checkOutput("rst_ins",    {16'd0, ins},       32'd0);
    checkOutput("rst_pc",     {24'd0, ins_pc},    32'd0);
    checkOutput("rst_halted", {31'd0, halted},    32'd0);
    rst = 1'b0;
  endtask

  initial begin
    compared    = 0;
    mismatched  = 0;
    rst         = 1'b1;
    ins_ready   = 1'b0;
    imem_gnt    = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 8'h00;
    halt        = 1'b0;

    // 1: streaming fetch, first word at cycle 2, then one per cycle
    $display("[TB] test 1: streaming fetch");
    resetDut();
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
    checkOutput("t1_req_c0",   {31'd0, imem_req},  32'd1);
    checkOutput("t1_addr_c0",  {24'd0, imem_addr}, 32'd0);
    checkOutput("t1_valid_c0", {31'd0, ins_valid}, 32'd0);
    tick();
    checkOutput("t1_valid_c1", {31'd0, ins_valid}, 32'd0);
    checkOutput("t1_addr_c1",  {24'd0, imem_addr}, 32'd1);
    tick();
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("t1_valid_%0d", i), {31'd0, ins_valid}, 32'd1);
      checkOutput($sformatf("t1_pc_%0d", i),    {24'd0, ins_pc},    i);
      checkOutput($sformatf("t1_ins_%0d", i),   {16'd0, ins},       32'h0400 + i);
      tick();
    end

    // 2: decoder stalled, queue fills to DEPTH and requests stop
    $display("[TB] test 2: fill and credit stop");
    resetDut();
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("t2_req_%0d", i),  {31'd0, imem_req},  32'd1);
      checkOutput($sformatf("t2_addr_%0d", i), {24'd0, imem_addr}, i);
      tick();
    end
    checkOutput("t2_req_c4", {31'd0, imem_req}, 32'd0);
    tick();
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
    checkOutput("t2_req_full", {31'd0, imem_req},  32'd0);
    checkOutput("t2_valid",    {31'd0, ins_valid}, 32'd1);
    checkOutput("t2_pc_head",  {24'd0, ins_pc},    32'd0);
    tick();
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
    checkOutput("t2_req_after_pop",  {31'd0, imem_req},  32'd1);
    checkOutput("t2_addr_after_pop", {24'd0, imem_addr}, 32'd4);
    checkOutput("t2_pc_next",        {24'd0, ins_pc},    32'd1);

    // 3: redirect with a word returning and three queued
    $display("[TB] test 3: redirect flush");
    resetDut();
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 4; i++) tick();
    applyStimulus(1'b0, 1'b1, 1'b1, 8'h40, 1'b0);
    checkOutput("t3_valid_pre", {31'd0, ins_valid},   32'd1);
    checkOutput("t3_rvalid",    {31'd0, imem_rvalid}, 32'd1);
    checkOutput("t3_req_redir", {31'd0, imem_req},    32'd0);
    tick();
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
    checkOutput("t3_valid_flushed", {31'd0, ins_valid}, 32'd0);
    checkOutput("t3_addr_new",      {24'd0, imem_addr}, 32'h40);
    checkOutput("t3_req_new",       {31'd0, imem_req},  32'd1);
    tick();
    checkOutput("t3_valid_c1", {31'd0, ins_valid}, 32'd0);
    tick();
    checkOutput("t3_valid_c2", {31'd0, ins_valid}, 32'd1);
    checkOutput("t3_pc_first", {24'd0, ins_pc},    32'h40);
    checkOutput("t3_ins_first",{16'd0, ins},       32'h0440);

    // 4: redirect to FE (req blocked even with credit), PC wraps FF -> 00
    $display("[TB] test 4: PC wrap");
    applyStimulus(1'b1, 1'b1, 1'b1, 8'hFE, 1'b0);
    checkOutput("t4_req_redir", {31'd0, imem_req}, 32'd0);
    tick();
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
    checkOutput("t4_addr_fe",  {24'd0, imem_addr}, 32'hFE);
    checkOutput("t4_valid_c0", {31'd0, ins_valid}, 32'd0);
    tick();
    tick();
    for (int i = 0; i < 4; i++) begin
      logic [7:0] epc;
      epc = 8'hFE + 8'(i);
      checkOutput($sformatf("t4_pc_%0d", i),  {24'd0, ins_pc}, {24'd0, epc});
      checkOutput($sformatf("t4_ins_%0d", i), {16'd0, ins},
                  {16'd0, 8'h00, epc} + 32'h0400);
      tick();
    end

    // 5: grant withheld for three cycles
    $display("[TB] test 5: grant stall");
    resetDut();
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("t5_req_%0d", i),   {31'd0, imem_req},  32'd1);
      checkOutput($sformatf("t5_addr_%0d", i),  {24'd0, imem_addr}, 32'd0);
      checkOutput($sformatf("t5_valid_%0d", i), {31'd0, ins_valid}, 32'd0);
      tick();
    end
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
    checkOutput("t5_addr_gnt", {24'd0, imem_addr}, 32'd0);
    tick();
    checkOutput("t5_rvalid",   {31'd0, imem_rvalid}, 32'd1);
    checkOutput("t5_valid_c1", {31'd0, ins_valid},   32'd0);
    tick();
    checkOutput("t5_valid_c2", {31'd0, ins_valid}, 32'd1);
    checkOutput("t5_pc",       {24'd0, ins_pc},    32'd0);

    // 6: HALT popped with a read outstanding; halt beats a concurrent redirect
    $display("[TB] test 6: halt and drain");
    resetDut();
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
    tick();
    tick();
    applyStimulus(1'b1, 1'b1, 1'b1, 8'h80, 1'b1);
    checkOutput("t6_valid_head", {31'd0, ins_valid},   32'd1);
    checkOutput("t6_rvalid",     {31'd0, imem_rvalid}, 32'd1);
    checkOutput("t6_req_halt",   {31'd0, imem_req},    32'd0);
    tick();
    applyStimulus(1'b1, 1'b1, 1'b1, 8'h80, 1'b0);
    checkOutput("t6_valid_drain",  {31'd0, ins_valid}, 32'd0);
    checkOutput("t6_req_drain",    {31'd0, imem_req},  32'd0);
    checkOutput("t6_halted_drain", {31'd0, halted},    32'd0);
    tick();
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("t6_halted_%0d", i), {31'd0, halted},    32'd1);
      checkOutput($sformatf("t6_req_%0d", i),    {31'd0, imem_req},  32'd0);
      checkOutput($sformatf("t6_valid_%0d", i),  {31'd0, ins_valid}, 32'd0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
